// File: rtl/clic_sched_pkg.sv
// Shared types and helpers for the CLIC interrupt scheduler.
package clic_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      PRESENT = 2'd2,
      CLAIM   = 2'd3
   } sched_state_e;

   typedef struct packed {
      logic [7:0] level;
      logic       shv;
   } cand_t;

   // Unimplemented intctl LSBs read as 1, so they never break a tie.
   function automatic logic [7:0] mask_level(input logic [7:0] lvl, input int bits);
      return lvl | (8'hFF >> bits);
   endfunction

endpackage

// File: rtl/clic_prio_cmp.sv
// Eligibility of one source plus its level compare against the current best.
module clic_prio_cmp
   import clic_sched_pkg::*;
#(
   parameter int INTCTLBITS = 8,
   parameter int VsidWidth  = 6
)(
   input  logic                 ip,
   input  logic                 ie,
   input  logic                 intv,
   input  logic [VsidWidth-1:0] vsid,
   input  logic [7:0]           intctl,
   input  logic                 tgt_vs,
   input  logic [VsidWidth-1:0] active_vsid,
   input  logic [7:0]           thresh,
   input  logic                 best_valid,
   input  logic [7:0]           best_level,
   output logic                 eligible,
   output logic                 better,
   output logic [7:0]           level
);

   logic ctx_ok;

   assign level    = mask_level(intctl, INTCTLBITS);
   assign ctx_ok   = tgt_vs ? (intv && (vsid == active_vsid)) : !intv;
   assign eligible = ip && ie && (level > thresh) && ctx_ok;
   // >= lets a later (higher) index win a level tie.
   assign better   = eligible && (!best_valid || (level >= best_level));

endmodule

// File: rtl/clic_irq_scheduler.sv
// Sequential CLIC arbiter: scans one source per cycle, presents the winner
// with a valid/ready handshake and pulses a pending-clear for edge sources.
module clic_irq_scheduler
   import clic_sched_pkg::*;
#(
   parameter  int N_SOURCE   = 32,
   parameter  int INTCTLBITS = 8,
   parameter  int VsidWidth  = 6,
   localparam int IdW        = $clog2(N_SOURCE)
)(
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               en_i,
   input  logic                               tgt_vs_i,
   input  logic [VsidWidth-1:0]               active_vsid_i,
   input  logic [7:0]                         thresh_i,
   input  logic [N_SOURCE-1:0]                ip_i,
   input  logic [N_SOURCE-1:0]                ie_i,
   input  logic [N_SOURCE-1:0]                le_i,
   input  logic [N_SOURCE-1:0]                shv_i,
   input  logic [N_SOURCE-1:0][7:0]           intctl_i,
   input  logic [N_SOURCE-1:0]                intv_i,
   input  logic [N_SOURCE-1:0][VsidWidth-1:0] vsid_i,
   output logic                               irq_valid_o,
   input  logic                               irq_ready_i,
   output logic [IdW-1:0]                     irq_id_o,
   output logic [7:0]                         irq_level_o,
   output logic                               irq_shv_o,
   output logic                               ip_clr_o,
   output logic [IdW-1:0]                     ip_clr_id_o
);

   localparam logic [IdW-1:0] LAST = IdW'(N_SOURCE - 1);

   sched_state_e         state;
   logic [IdW-1:0]       idx;
   logic [IdW-1:0]       best_id;
   cand_t                best;
   logic                 best_valid;
   logic                 prev_tgt_vs;
   logic [VsidWidth-1:0] prev_vsid;
   logic                 ctx_changed;

   logic       scan_better, scan_elig;
   logic [7:0] scan_level;
   logic       chk_elig, chk_better;
   logic [7:0] chk_level;
   logic       unused_chk;

   assign ctx_changed = (tgt_vs_i != prev_tgt_vs) || (active_vsid_i != prev_vsid);

   clic_prio_cmp #(.INTCTLBITS(INTCTLBITS), .VsidWidth(VsidWidth)) u_scan_cmp (
      .ip(ip_i[idx]), .ie(ie_i[idx]), .intv(intv_i[idx]), .vsid(vsid_i[idx]),
      .intctl(intctl_i[idx]), .tgt_vs(tgt_vs_i), .active_vsid(active_vsid_i),
      .thresh(thresh_i), .best_valid(best_valid), .best_level(best.level),
      .eligible(scan_elig), .better(scan_better), .level(scan_level)
   );

   // Recheck of the presented source; only its eligibility matters here.
   clic_prio_cmp #(.INTCTLBITS(INTCTLBITS), .VsidWidth(VsidWidth)) u_chk_cmp (
      .ip(ip_i[irq_id_o]), .ie(ie_i[irq_id_o]), .intv(intv_i[irq_id_o]),
      .vsid(vsid_i[irq_id_o]), .intctl(intctl_i[irq_id_o]), .tgt_vs(tgt_vs_i),
      .active_vsid(active_vsid_i), .thresh(thresh_i), .best_valid(1'b0),
      .best_level(8'h00), .eligible(chk_elig), .better(chk_better), .level(chk_level)
   );

   assign unused_chk = &{1'b0, chk_better, chk_level, scan_elig};

   always_ff @(posedge clk_i) begin
      prev_tgt_vs <= tgt_vs_i;
      prev_vsid   <= active_vsid_i;
      if (rst_i) begin
         state       <= IDLE;
         idx         <= '0;
         best        <= '0;
         best_id     <= '0;
         best_valid  <= 1'b0;
         irq_valid_o <= 1'b0;
         irq_id_o    <= '0;
         irq_level_o <= '0;
         irq_shv_o   <= 1'b0;
         ip_clr_o    <= 1'b0;
         ip_clr_id_o <= '0;
      end else begin
         ip_clr_o <= 1'b0;
         case (state)
            IDLE: begin
               irq_valid_o <= 1'b0;
               if (en_i) begin
                  state      <= SCAN;
                  idx        <= '0;
                  best       <= '0;
                  best_id    <= '0;
                  best_valid <= 1'b0;
               end
            end
            SCAN: begin
               if (!en_i) begin
                  state <= IDLE;
               end else if (ctx_changed) begin
                  idx        <= '0;
                  best       <= '0;
                  best_id    <= '0;
                  best_valid <= 1'b0;
               end else if (idx == LAST) begin
                  if (scan_better || best_valid) begin
                     state       <= PRESENT;
                     irq_valid_o <= 1'b1;
                     if (scan_better) begin
                        irq_id_o    <= idx;
                        irq_level_o <= scan_level;
                        irq_shv_o   <= shv_i[idx];
                     end else begin
                        irq_id_o    <= best_id;
                        irq_level_o <= best.level;
                        irq_shv_o   <= best.shv;
                     end
                  end
                  idx        <= '0;
                  best       <= '0;
                  best_id    <= '0;
                  best_valid <= 1'b0;
               end else begin
                  if (scan_better) begin
                     best       <= '{level: scan_level, shv: shv_i[idx]};
                     best_id    <= idx;
                     best_valid <= 1'b1;
                  end
                  idx <= idx + IdW'(1);
               end
            end
            PRESENT: begin
               // A completed handshake wins over a falling enable so the clear is never lost.
               if (irq_ready_i) begin
                  irq_valid_o <= 1'b0;
                  ip_clr_o    <= le_i[irq_id_o];
                  ip_clr_id_o <= irq_id_o;
                  state       <= CLAIM;
               end else if (!en_i) begin
                  irq_valid_o <= 1'b0;
                  state       <= IDLE;
               end else if (!chk_elig) begin
                  irq_valid_o <= 1'b0;
                  state       <= SCAN;
                  idx         <= '0;
                  best        <= '0;
                  best_id     <= '0;
                  best_valid  <= 1'b0;
               end
            end
            CLAIM: begin
               state      <= en_i ? SCAN : IDLE;
               idx        <= '0;
               best       <= '0;
               best_id    <= '0;
               best_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clic_irq_scheduler.sv
// Directed cases plus randomized traffic checked against a behavioural scheduler model.
module tb_clic_irq_scheduler;
   localparam int N = 8, IdW = 3, VW = 6, ICB = 8;
   localparam int M_IDLE = 0, M_SCAN = 1, M_PRESENT = 2, M_CLAIM = 3;

   logic clk, rst, en, tgt_vs, ready;
   logic [VW-1:0] avsid;
   logic [7:0] thresh;
   logic [N-1:0] ip, ie, le, shv, intv;
   logic [N-1:0][7:0] intctl;
   logic [N-1:0][VW-1:0] vsid;
   logic valid, dshv, clr;
   logic [IdW-1:0] id, clr_id;
   logic [7:0] lvl;

   int checks = 0, passed = 0;
   bit started = 0;

   clic_irq_scheduler #(.N_SOURCE(N), .INTCTLBITS(ICB), .VsidWidth(VW)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .tgt_vs_i(tgt_vs), .active_vsid_i(avsid),
      .thresh_i(thresh), .ip_i(ip), .ie_i(ie), .le_i(le), .shv_i(shv),
      .intctl_i(intctl), .intv_i(intv), .vsid_i(vsid), .irq_valid_o(valid),
      .irq_ready_i(ready), .irq_id_o(id), .irq_level_o(lvl), .irq_shv_o(dshv),
      .ip_clr_o(clr), .ip_clr_id_o(clr_id)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {int idx; int lvl; bit shv;} hit_t;
   hit_t hits[$];
   hit_t h;
   int m_mode = M_IDLE, m_k = 0, m_id = 0, m_lvl = 0, m_clr_id = 0, top;
   bit m_valid = 0, m_clr = 0, m_shv = 0, p_tgt = 0;
   int p_vsid = 0;

   function automatic int mlevel(int s);
      return int'(intctl[s]) | (255 >> ICB);
   endfunction

   function automatic bit elig(int s);
      bit ctx;
      ctx = tgt_vs ? (intv[s] && int'(vsid[s]) == int'(avsid)) : !intv[s];
      return ip[s] && ie[s] && (mlevel(s) > int'(thresh)) && ctx;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode = M_IDLE; m_k = 0; hits.delete();
         m_valid = 0; m_clr = 0; m_id = 0; m_lvl = 0; m_shv = 0; m_clr_id = 0;
      end else begin
         m_clr = 0;
         case (m_mode)
            M_IDLE: if (en) begin m_mode = M_SCAN; m_k = 0; hits.delete(); end
            M_SCAN: begin
               if (!en) m_mode = M_IDLE;
               else if (tgt_vs != p_tgt || int'(avsid) != p_vsid) begin m_k = 0; hits.delete(); end
               else begin
                  if (elig(m_k)) begin h.idx = m_k; h.lvl = mlevel(m_k); h.shv = shv[m_k]; hits.push_back(h); end
                  if (m_k == N - 1) begin
                     if (hits.size() > 0) begin
                        // highest level wins; among equals the highest index (latest hit)
                        top = -1;
                        foreach (hits[i]) if (hits[i].lvl > top) top = hits[i].lvl;
                        foreach (hits[i]) if (hits[i].lvl == top) begin
                           m_id = hits[i].idx; m_lvl = top; m_shv = hits[i].shv;
                        end
                        m_valid = 1; m_mode = M_PRESENT;
                     end
                     m_k = 0; hits.delete();
                  end else m_k++;
               end
            end
            M_PRESENT: begin
               if (ready) begin m_valid = 0; m_clr = le[m_id]; m_clr_id = m_id; m_mode = M_CLAIM; end
               else if (!en) begin m_valid = 0; m_mode = M_IDLE; end
               else if (!elig(m_id)) begin m_valid = 0; m_mode = M_SCAN; m_k = 0; hits.delete(); end
            end
            default: begin m_mode = en ? M_SCAN : M_IDLE; m_k = 0; hits.delete(); end
         endcase
      end
      p_tgt = tgt_vs; p_vsid = int'(avsid);
   end

   always @(negedge clk) if (started) begin
      chk("valid", valid, m_valid);
      chk("ip_clr", clr, m_clr);
      if (m_valid) begin
         chk("irq_id", id, m_id);
         chk("irq_level", lvl, m_lvl);
         chk("irq_shv", dshv, m_shv);
      end
      if (m_clr) chk("ip_clr_id", clr_id, m_clr_id);
   end

   // ---------------- stimulus ----------------
   task automatic wait_valid(input int lim, output int n);
      n = 0;
      while (!valid && n < lim) begin @(negedge clk); n++; end
      chk("wait_valid_bound", valid, 1);
   endtask

   task automatic quiet();
      ip = '0; ie = '0; le = '0; shv = '0; intv = '0; intctl = '0; vsid = '0;
      tgt_vs = 0; avsid = '0; thresh = '0; ready = 0;
   endtask

   initial begin : main
      int n, seen, b;
      rst = 1; en = 0; quiet();
      @(posedge clk); started = 1;
      @(negedge clk);
      chk("rst_valid", valid, 0); chk("rst_clr", clr, 0); chk("rst_id", id, 0);
      chk("rst_level", lvl, 0); chk("rst_shv", dshv, 0); chk("rst_clr_id", clr_id, 0);
      rst = 0;

      // two sources, higher level wins; one idle cycle plus a full 8-cycle scan
      ip[2] = 1; ie[2] = 1; intctl[2] = 8'h40; shv[2] = 1;
      ip[5] = 1; ie[5] = 1; intctl[5] = 8'h80;
      en = 1;
      wait_valid(40, n);
      chk("scan_latency", n, 9); chk("case1_id", id, 5); chk("case1_level", lvl, 8'h80);
      repeat (3) @(negedge clk);
      chk("case1_hold", valid, 1);
      ie[5] = 0;
      @(negedge clk); chk("drop_valid", valid, 0);
      ie[2] = 0; seen = 0;
      repeat (30) begin @(negedge clk); seen += int'(valid); end
      chk("nothing_eligible", seen, 0);

      // level tie goes to the higher index; edge source cleared once
      en = 0; @(negedge clk); quiet();
      ip[3] = 1; ie[3] = 1; intctl[3] = 8'h60;
      ip[6] = 1; ie[6] = 1; intctl[6] = 8'h60; le[6] = 1;
      en = 1;
      wait_valid(40, n); chk("tie_id", id, 6);
      ready = 1;
      @(negedge clk); ready = 0;
      chk("claim_valid", valid, 0); chk("claim_clr", clr, 1); chk("claim_clr_id", clr_id, 6);
      seen = 0;
      repeat (10) begin @(negedge clk); seen += int'(clr); end
      chk("single_pulse", seen, 0);

      // handshake in the same cycle enable drops: pulse still issued
      wait_valid(40, n);
      ready = 1; en = 0;
      @(negedge clk); ready = 0;
      chk("en_fall_clr", clr, 1); chk("en_fall_clr_id", clr_id, 6);
      @(negedge clk); chk("en_fall_idle_clr", clr, 0); chk("en_fall_idle_valid", valid, 0);

      // virtual supervisor context: only matching vsid is ever presented
      quiet();
      ip[1] = 1; ie[1] = 1; intv[1] = 1; vsid[1] = 2; intctl[1] = 8'h20;
      ip[4] = 1; ie[4] = 1; intv[4] = 1; vsid[4] = 3; intctl[4] = 8'hF0;
      tgt_vs = 1; avsid = 2; en = 1;
      wait_valid(40, n); chk("vs_id", id, 1); chk("vs_level", lvl, 8'h20);
      seen = 0;
      repeat (60) begin
         ready = ($urandom_range(0, 2) == 0);
         @(negedge clk); seen += int'(valid && id == 3'd4);
      end
      ready = 0;
      chk("vs_never_src4", seen, 0);

      // level equal to threshold never qualifies
      en = 0; @(negedge clk); quiet();
      ip[0] = 1; ie[0] = 1; intctl[0] = 8'h80; thresh = 8'h80; en = 1;
      seen = 0;
      repeat (30) begin @(negedge clk); seen += int'(valid); end
      chk("at_thresh_never_valid", seen, 0);

      // reset during a handshake
      thresh = 8'h00;
      wait_valid(40, n);
      le[0] = 1; ready = 1; rst = 1;
      @(negedge clk);
      chk("mid_rst_valid", valid, 0); chk("mid_rst_clr", clr, 0); chk("mid_rst_id", id, 0);
      chk("mid_rst_level", lvl, 0); chk("mid_rst_shv", dshv, 0); chk("mid_rst_clr_id", clr_id, 0);
      rst = 0; ready = 0; en = 0;
      @(negedge clk); chk("post_rst_clr", clr, 0);

      // randomized traffic
      for (int s = 0; s < N; s++) begin
         intctl[s] = 8'(32 * $urandom_range(1, 5));
         vsid[s] = VW'($urandom_range(0, 2));
      end
      ip = N'($urandom); ie = N'($urandom); le = N'($urandom); shv = N'($urandom);
      intv = N'($urandom); tgt_vs = 0; avsid = 2;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 499) == 0);
         en = ($urandom_range(0, 59) != 0);
         ready = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 4) == 0) begin b = $urandom_range(0, N - 1); ip[b] = ~ip[b]; end
         if ($urandom_range(0, 9) == 0) begin b = $urandom_range(0, N - 1); ie[b] = ~ie[b]; end
         if ($urandom_range(0, 19) == 0) begin b = $urandom_range(0, N - 1); intctl[b] = 8'(32 * $urandom_range(1, 5)); end
         if ($urandom_range(0, 29) == 0) begin b = $urandom_range(0, N - 1); intv[b] = ~intv[b]; le[b] = ~le[b]; end
         if ($urandom_range(0, 49) == 0) tgt_vs = ~tgt_vs;
         if ($urandom_range(0, 49) == 0) avsid = VW'($urandom_range(0, 2));
         if ($urandom_range(0, 99) == 0) thresh = 8'(48 * $urandom_range(0, 2));
      end
      rst = 0; en = 0;
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/clic_irq_scheduler.md
CLIC_IRQ_SCHEDULER -- requirements
Module: clic_irq_scheduler

Interface
REQ-001 Parameter N_SOURCE, default 32, number of interrupt sources; N_SOURCE SHALL be a power of two, at least 4.
REQ-002 Parameter INTCTLBITS, default 8, number of implemented MSBs of intctl that take part in comparison.
REQ-003 Parameter VsidWidth, default 6, width of the VS context id.
REQ-004 Ports SHALL be as follows; IdW = $clog2(N_SOURCE).
clk_i  in  1  single clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
en_i  in  1  scheduler enable
tgt_vs_i  in  1  0 = machine context, 1 = virtual supervisor context
active_vsid_i  in  VsidWidth  VS context currently running on the core
thresh_i  in  8  interrupt level threshold
ip_i  in  N_SOURCE  pending bits
ie_i  in  N_SOURCE  enable bits
le_i  in  N_SOURCE  1 = edge-triggered
shv_i  in  N_SOURCE  selective hardware vectoring
intctl_i  in  8 x N_SOURCE  per-source control/level
intv_i  in  1 x N_SOURCE  per-source virtualised flag
vsid_i  in  VsidWidth x N_SOURCE  per-source VS id
irq_valid_o  out  1  candidate is presented to the core
irq_ready_i  in  1  core accepts the candidate
irq_id_o  out  IdW  winning source index
irq_level_o  out  8  winning intctl, with unimplemented LSBs forced to 1
irq_shv_o  out  1  shv of the winner
ip_clr_o  out  1  one-cycle pulse that clears the pending bit of an edge source
ip_clr_id_o  out  IdW  index to clear

Function
REQ-005 A source is eligible when ip_i & ie_i are both set, its masked level is greater than thresh_i, and its context matches: tgt_vs_i=0 requires intv_i=0; tgt_vs_i=1 requires intv_i=1 and vsid_i equal to active_vsid_i.
REQ-006 The FSM SHALL have the states IDLE, SCAN, PRESENT and CLAIM.
REQ-007 IDLE: outputs are inactive; the FSM SHALL move to SCAN when en_i=1 and clear the scan index and the best-candidate registers.
REQ-008 SCAN: the FSM SHALL examine exactly one source per cycle, in index order 0..N_SOURCE-1.
REQ-009 SCAN: a source SHALL replace the best candidate if it is eligible and its level is >= the best level, so that a level tie goes to the higher index.
REQ-010 SCAN: after index N_SOURCE-1 the FSM SHALL go to PRESENT if a candidate was found, otherwise restart SCAN from index 0; a full scan takes N_SOURCE cycles.
REQ-011 PRESENT: irq_valid_o SHALL be 1, and irq_id_o, irq_level_o and irq_shv_o SHALL be driven from registers and stay stable while valid is high and ready is low.
REQ-012 PRESENT: if irq_ready_i=1, the handshake completes in that cycle and the FSM SHALL go to CLAIM.
REQ-013 PRESENT: if irq_ready_i=0 and the presented source is no longer eligible (REQ-005 rechecked every cycle), irq_valid_o SHALL drop in the next cycle and the FSM SHALL go to SCAN from index 0.
REQ-014 PRESENT: valid SHALL NOT be withdrawn for a higher-level arrival; preemption is only re-evaluated after the next scan.
REQ-015 CLAIM, one cycle: ip_clr_o SHALL pulse for exactly one cycle, with ip_clr_id_o equal to the accepted id, only if le_i of that id is 1; the FSM SHALL then go to SCAN from index 0.
REQ-016 en_i=0 in any state SHALL force IDLE in the next cycle, and a pending handshake is abandoned.
REQ-017 If the handshake completes in the same cycle as en_i falls, the clear pulse SHALL still be issued: CLAIM takes priority, then IDLE.
REQ-018 A change of tgt_vs_i or active_vsid_i during SCAN SHALL restart the scan from index 0 and clear the best-candidate registers.

Reset
REQ-019 While rst_i=1 at a clock edge: the state SHALL be IDLE; irq_valid_o, ip_clr_o, irq_id_o, irq_level_o, irq_shv_o and ip_clr_id_o SHALL be 0; the scan index and best-candidate registers SHALL be cleared.
REQ-020 Reset asserted in any state, including mid-handshake, SHALL take effect at the next edge, and no clear pulse is issued.

Structure
REQ-021 Package clic_sched_pkg SHALL hold the state enum sched_state_e and a function that masks a level to INTCTLBITS.
REQ-022 The eligibility and compare logic SHALL be one combinational sub-module, clic_prio_cmp, instanced twice: once for the scan and once for the PRESENT recheck.

Verification
REQ-023 Case: N_SOURCE=8, thresh=0, sources 2 (level 0x40) and 5 (level 0x80) pending and enabled, machine context -> valid after 8 scan cycles with id=5, level=0x80.
REQ-024 Case: sources 3 and 6 both at level 0x60 -> id=6; with le[6]=1 and ready=1 -> ip_clr_o pulses once with ip_clr_id_o=6.
REQ-025 Case: tgt_vs=1, active_vsid=2; source 1 has intv=1, vsid=2, level 0x20; source 4 has intv=1, vsid=3, level 0xF0 -> id=1 is presented; source 4 is never presented.
REQ-026 Case: presenting id=5, ready held low, ie[5] cleared -> valid low the next cycle and a rescan starts; with nothing eligible, valid stays 0.
REQ-027 Case: thresh=0x80 and only source level 0x80 -> never valid. Separately: reset asserted while valid=1 -> all outputs 0 the next cycle and no ip_clr pulse.
